// File: rtl/cic_sched_pkg.sv
// Shared types and helpers for the CIC channel scheduler.
package cic_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Width of a decimation counter that spans 0..decim-1.
    function automatic int cnt_width(input int decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan requesters starting at ptr, wrapping around, and pick the first.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cic_chan_sched.sv
// Time-multiplexes N_CH sample channels onto one shared CIC filter input,
// tagging each issued sample with its channel and end-of-frame strobe.
module cic_chan_sched
    import cic_sched_pkg::*;
#(
    parameter  int NBW_IN = 8,
    parameter  int N_CH   = 4,
    parameter  int DECIM  = 64,
    localparam int NBW_CH = $clog2(N_CH)
) (
    input  logic                     clock,
    input  logic                     rst_async_n,
    input  logic [N_CH*NBW_IN-1:0]   i_ch_data,
    input  logic [N_CH-1:0]          i_ch_valid,
    output logic [N_CH-1:0]          o_ch_ready,
    input  logic                     i_enable,
    input  logic                     i_flush,
    output logic                     o_flush_done,
    output logic [NBW_IN-1:0]        o_filt_data,
    output logic                     o_filt_valid,
    output logic [NBW_CH-1:0]        o_filt_ch,
    output logic                     o_filt_dump
);

    localparam int CNT_W = cnt_width(DECIM);

    sched_state_t      state;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   gnt;
    logic [N_CH-1:0]   accept;
    logic [NBW_IN-1:0] buf_data [N_CH];
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [NBW_CH-1:0] ptr;
    logic [NBW_CH-1:0] gnt_idx;
    logic              gnt_any;
    logic              drained;
    logic              frame_end;

    // Buffers only take new samples in RUN; draining closes the inputs.
    assign o_ch_ready = ~full & {N_CH{state == RUN}};
    assign accept     = i_ch_valid & o_ch_ready;
    assign req        = full & {N_CH{i_enable}};
    assign drained    = (full == '0) && i_enable;
    assign frame_end  = (cnt[gnt_idx] == CNT_W'(DECIM - 1));

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // One-entry holding register per channel; a grant empties it.
    always_ff @(posedge clock or negedge rst_async_n) begin
        if (!rst_async_n) begin
            full <= '0;
            for (int c = 0; c < N_CH; c++) buf_data[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (accept[c]) begin
                    full[c]     <= 1'b1;
                    buf_data[c] <= i_ch_data[c*NBW_IN +: NBW_IN];
                end else if (gnt[c]) begin
                    full[c] <= 1'b0;
                end
            end
        end
    end

    // Flush sequencing, round-robin pointer and per-channel frame counters.
    always_ff @(posedge clock or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state <= RUN;
            ptr   <= '0;
            for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
        end else begin
            case (state)
                RUN:     if (i_flush) state <= DRAIN;
                DRAIN:   if (drained) state <= DONE;
                default: state <= RUN;
            endcase
            // DONE is only reached with every buffer empty, so no grant competes here.
            if (state == DONE) begin
                ptr <= '0;
                for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
            end else if (gnt_any) begin
                ptr          <= (gnt_idx == NBW_CH'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                cnt[gnt_idx] <= frame_end ? '0 : cnt[gnt_idx] + 1'b1;
            end
        end
    end

    // Registered filter-side outputs; data and channel hold while idle.
    always_ff @(posedge clock or negedge rst_async_n) begin
        if (!rst_async_n) begin
            o_filt_valid <= 1'b0;
            o_filt_data  <= '0;
            o_filt_ch    <= '0;
            o_filt_dump  <= 1'b0;
            o_flush_done <= 1'b0;
        end else begin
            o_filt_valid <= gnt_any;
            o_filt_dump  <= gnt_any && frame_end;
            o_flush_done <= (state == DRAIN) && drained;
            if (gnt_any) begin
                o_filt_data <= buf_data[gnt_idx];
                o_filt_ch   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_cic_chan_sched.sv
// Self-checking bench for cic_chan_sched against a behavioural channel model.
module tb_cic_chan_sched;

    localparam int NBW_IN = 8;
    localparam int N_CH   = 4;
    localparam int DECIM  = 4;
    localparam int NBW_CH = 2;

    logic                   clock = 1'b0;
    logic                   rst_async_n = 1'b0;
    logic [N_CH*NBW_IN-1:0] ch_data = '0;
    logic [N_CH-1:0]        ch_valid = '0;
    logic [N_CH-1:0]        ch_ready;
    logic                   enable = 1'b1;
    logic                   flush = 1'b0;
    logic                   flush_done;
    logic [NBW_IN-1:0]      filt_data;
    logic                   filt_valid;
    logic [NBW_CH-1:0]      filt_ch;
    logic                   filt_dump;

    always #5 clock = ~clock;

    cic_chan_sched #(.NBW_IN(NBW_IN), .N_CH(N_CH), .DECIM(DECIM)) dut (
        .clock        (clock),
        .rst_async_n  (rst_async_n),
        .i_ch_data    (ch_data),
        .i_ch_valid   (ch_valid),
        .o_ch_ready   (ch_ready),
        .i_enable     (enable),
        .i_flush      (flush),
        .o_flush_done (flush_done),
        .o_filt_data  (filt_data),
        .o_filt_valid (filt_valid),
        .o_filt_ch    (filt_ch),
        .o_filt_dump  (filt_dump)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: buffered samples, frame position per channel, next channel in turn.
    bit          m_full [N_CH];
    logic [7:0]  m_data [N_CH];
    int          m_cnt  [N_CH];
    int          m_next;
    bit          m_draining;
    bit          m_done_pending;

    logic [3:0]  e_rdy, o_rdy;
    bit          e_valid, e_dump, e_done;
    logic [1:0]  e_ch;
    logic [7:0]  e_data;

    function automatic logic [16:0] obs_vec();
        return {o_rdy, filt_valid, filt_ch, filt_data, filt_dump, flush_done};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {e_rdy, e_valid, e_ch, e_data, e_dump, e_done};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_full[c] = 0; m_data[c] = '0; m_cnt[c] = 0;
        end
        m_next = 0; m_draining = 0; m_done_pending = 0;
        e_valid = 0; e_dump = 0; e_done = 0; e_ch = '0; e_data = '0;
        e_rdy = '1; o_rdy = '1;
    endtask

    // Advance DUT and model by one clock; leaves time 1 unit after the edge.
    task automatic step();
        int  g;
        int  idx;
        bit  any_full;
        for (int c = 0; c < N_CH; c++)
            e_rdy[c] = !m_full[c] && !m_draining && !m_done_pending;
        o_rdy = ch_ready;
        @(posedge clock);
        g = -1;
        any_full = 0;
        for (int c = 0; c < N_CH; c++) any_full |= m_full[c];
        if (enable) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = (m_next + k) % N_CH;
                if (g < 0 && m_full[idx]) g = idx;
            end
        end
        e_valid = (g >= 0);
        e_dump  = 0;
        e_done  = m_draining && !any_full && enable;
        if (g >= 0) begin
            e_data    = m_data[g];
            e_ch      = 2'(g);
            e_dump    = (m_cnt[g] == DECIM - 1);
            m_full[g] = 0;
            m_cnt[g]  = (m_cnt[g] + 1) % DECIM;
            m_next    = (g + 1) % N_CH;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (ch_valid[c] && e_rdy[c]) begin
                m_full[c] = 1;
                m_data[c] = ch_data[c*NBW_IN +: NBW_IN];
            end
        end
        if (m_done_pending) begin
            m_done_pending = 0;
            m_next = 0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        end else if (m_draining) begin
            if (!any_full && enable) begin
                m_draining = 0; m_done_pending = 1;
            end
        end else if (flush) begin
            m_draining = 1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_async_n = 1'b0;
        ch_valid = '0; ch_data = '0; enable = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        rst_async_n = 1'b1;
    endtask

    task automatic randomize_data();
        for (int c = 0; c < N_CH; c++) ch_data[c*NBW_IN +: NBW_IN] = 8'($urandom);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ch_ready, filt_valid, filt_ch, filt_data, filt_dump, flush_done} !== {4'hF, 1'b0, 2'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h",
                     {ch_ready, filt_valid, filt_ch, filt_data, filt_dump, flush_done},
                     {4'hF, 1'b0, 2'b0, 8'h00, 1'b0, 1'b0});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_all_four();
        int n;
        apply_reset();
        ch_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        ch_valid = 4'hF;
        step();
        ch_valid = '0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_four_model cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i < 4) begin
                checks++;
                if ({filt_valid, filt_ch, filt_data} !== {1'b1, 2'(i), 8'(8'h10 + i)}) begin
                    errors++;
                    $display("FAIL all_four_order cyc=%0d got=%h want=%h", i,
                             {filt_valid, filt_ch, filt_data}, {1'b1, 2'(i), 8'(8'h10 + i)});
                end
            end
            if (filt_valid) n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL all_four_count got=%0d want=4", n);
        end
    endtask

    task automatic test_decim();
        int n;
        apply_reset();
        ch_valid = 4'b0100;
        n = 0;
        for (int i = 0; i < 26; i++) begin
            randomize_data();
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL decim_model cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (filt_valid !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL decim_rate cyc=%0d got=%0b want=%0b", i, filt_valid, (i % 2 == 1));
            end
            if (filt_valid) begin
                n++;
                checks++;
                if (filt_dump !== (n % 4 == 0)) begin
                    errors++;
                    $display("FAIL decim_dump sample=%0d got=%0b want=%0b", n, filt_dump, (n % 4 == 0));
                end
            end
        end
        ch_valid = '0;
    endtask

    task automatic test_ptr();
        logic [1:0] want [4];
        want = '{2'd3, 2'd0, 2'd1, 2'd0};
        apply_reset();
        randomize_data();
        ch_valid = 4'b0001;
        step();
        ch_valid = '0;
        step();
        enable = 1'b0;
        randomize_data();
        ch_valid = 4'b1001;
        step();
        ch_valid = '0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec() || {filt_valid, filt_ch} !== {1'b1, want[i]}) begin
                errors++;
                $display("FAIL ptr_order cyc=%0d got=%h/%0d want=%h/%0d", i, obs_vec(), filt_ch, exp_vec(), want[i]);
            end
        end
        enable = 1'b0;
        randomize_data();
        ch_valid = 4'b0011;
        step();
        ch_valid = '0;
        enable = 1'b1;
        for (int i = 2; i < 4; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec() || {filt_valid, filt_ch} !== {1'b1, want[i]}) begin
                errors++;
                $display("FAIL ptr_resume cyc=%0d got=%h/%0d want=%h/%0d", i, obs_vec(), filt_ch, exp_vec(), want[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        enable = 1'b0;
        randomize_data();
        ch_valid = 4'hF;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({filt_valid, o_rdy} !== 5'b0 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL enable_hold cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        ch_valid = '0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec() || {filt_valid, filt_ch} !== {1'b1, 2'(i)}) begin
                errors++;
                $display("FAIL enable_resume cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        int nvalid, ndone, last_valid, done_at, n1;
        apply_reset();
        ch_valid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            step();
        end
        ch_valid = '0;
        step();
        enable = 1'b0;
        randomize_data();
        ch_valid = 4'b0111;
        step();
        ch_valid = '0;
        enable = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        nvalid = filt_valid ? 1 : 0;
        checks++;
        if (ch_ready !== 4'h0) begin
            errors++;
            $display("FAIL flush_ready got=%h want=0", ch_ready);
        end
        ndone = 0; last_valid = -1; done_at = -9;
        for (int j = 0; j < 6; j++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL flush_model cyc=%0d got=%h want=%h", j, obs_vec(), exp_vec());
            end
            if (filt_valid) begin nvalid++; last_valid = j; end
            if (flush_done) begin ndone++; done_at = j; end
        end
        checks++;
        if (nvalid !== 3 || ndone !== 1 || done_at !== last_valid + 1) begin
            errors++;
            $display("FAIL flush_seq got=%0d/%0d/%0d want=3/1/%0d", nvalid, ndone, done_at, last_valid + 1);
        end
        ch_valid = 4'b0010;
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            randomize_data();
            if (i == 8) ch_valid = '0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL flush_cnt_model cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (filt_valid) begin
                n1++;
                checks++;
                if (filt_dump !== (n1 == 4)) begin
                    errors++;
                    $display("FAIL flush_cnt_clear sample=%0d got=%0b want=%0b", n1, filt_dump, (n1 == 4));
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            randomize_data();
            ch_valid = 4'($urandom);
            enable   = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        ch_valid = '0; enable = 1'b1; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        ch_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        #2;
        rst_async_n = 1'b0;
        #1;
        checks++;
        if ({ch_ready, filt_valid, filt_ch, filt_data, filt_dump, flush_done} !== {4'hF, 1'b0, 2'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h",
                     {ch_ready, filt_valid, filt_ch, filt_data, filt_dump, flush_done},
                     {4'hF, 1'b0, 2'b0, 8'h00, 1'b0, 1'b0});
        end
        ch_valid = '0;
        model_reset();
        @(posedge clock);
        #1;
        rst_async_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (filt_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_four();
        test_decim();
        test_ptr();
        test_enable_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
